// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding and bus widths for the DDS parallel port controller
package dds_pkg;

    localparam int DDS_AW = 8;
    localparam int DDS_DW = 8;

    typedef enum logic [3:0] {
        IDLE,
        CS_SU,
        A_LO,
        A_HI,
        D_LO,
        D_HI,
        CS_HD,
        IOUP,
        DONE
    } dds_state_t;

endpackage

// File: rtl/dds_rr_arb2.sv
// dds_rr_arb2: two-way round-robin arbiter; a lone requester always wins
module dds_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    logic last;

    // on contention, grant the port that did not win last time
    always_comb grant = !en ? 2'b00 : (&valid) ? (last ? 2'b01 : 2'b10) : valid;

    // remember the most recent winner; reset state makes port 0 win first
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) last <= 1'b1;
        else if (|grant) last <= grant[1];

endmodule

// File: rtl/dds_par_port_ctrl.sv
// dds_par_port_ctrl: sequences the DDS 8-bit parallel port for two requesters
module dds_par_port_ctrl
    import dds_pkg::*;
#(
    parameter int PCLK_HALF = 2,
    parameter int IOUP_W    = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_rw,
    input  logic [DDS_AW-1:0] req0_addr,
    input  logic [DDS_DW-1:0] req0_wdata,
    input  logic              req0_io_up,
    output logic              req0_done,
    output logic [DDS_DW-1:0] req0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_rw,
    input  logic [DDS_AW-1:0] req1_addr,
    input  logic [DDS_DW-1:0] req1_wdata,
    input  logic              req1_io_up,
    output logic              req1_done,
    output logic [DDS_DW-1:0] req1_rdata,
    output logic              busy,
    output logic              DDS_CSn,
    output logic              DDS_RWn,
    output logic              DDS_PCLK,
    output logic [DDS_AW-1:0] DDS_DataOut,
    output logic              DDS_ReadEn,
    input  logic [DDS_DW-1:0] DDS_DataIn,
    output logic              DDS_IOup
);

    localparam int CMAX = PCLK_HALF > IOUP_W ? PCLK_HALF : IOUP_W;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] PH_LD = CW'(PCLK_HALF - 1);
    localparam logic [CW-1:0] IW_LD = CW'(IOUP_W - 1);

    dds_state_t        state;
    logic [CW-1:0]     cnt;
    logic              own, rw, io_up, last, sel, fin;
    logic [DDS_DW-1:0] wdata, rbuf;
    logic [1:0]        grant;

    dds_rr_arb2 u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .valid ({req1_valid, req0_valid}),
        .en    (state == IDLE),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel        = grant[1];
    assign busy       = state != IDLE;
    assign last       = cnt == '0;

    // leave for DONE from CS_HD when no IO_update is due, or at the end of the IOUP pulse
    always_comb fin = (state == CS_HD && !(!rw && io_up)) || (state == IOUP && last);

    // port sequencer: every pin is set on entry to the state that owns its value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            own         <= 1'b0;
            rw          <= 1'b0;
            io_up       <= 1'b0;
            wdata       <= '0;
            rbuf        <= '0;
            DDS_CSn     <= 1'b1;
            DDS_RWn     <= 1'b1;
            DDS_PCLK    <= 1'b0;
            DDS_DataOut <= '0;
            DDS_ReadEn  <= 1'b0;
            DDS_IOup    <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: if (|grant) begin
                    own         <= sel;
                    rw          <= sel ? req1_rw : req0_rw;
                    io_up       <= sel ? req1_io_up : req0_io_up;
                    wdata       <= sel ? req1_wdata : req0_wdata;
                    DDS_CSn     <= 1'b0;
                    DDS_RWn     <= sel ? req1_rw : req0_rw;
                    DDS_DataOut <= sel ? req1_addr : req0_addr;
                    state       <= CS_SU;
                end
                CS_SU: begin
                    cnt   <= PH_LD;
                    state <= A_LO;
                end
                A_LO: if (last) begin
                    cnt      <= PH_LD;
                    DDS_PCLK <= 1'b1;
                    state    <= A_HI;
                end else cnt <= cnt - 1'b1;
                A_HI: if (last) begin
                    cnt         <= PH_LD;
                    DDS_PCLK    <= 1'b0;
                    DDS_ReadEn  <= rw;
                    DDS_DataOut <= rw ? '0 : wdata;
                    state       <= D_LO;
                end else cnt <= cnt - 1'b1;
                D_LO: if (last) begin
                    cnt      <= PH_LD;
                    DDS_PCLK <= 1'b1;
                    state    <= D_HI;
                end else cnt <= cnt - 1'b1;
                D_HI: if (last) begin
                    rbuf        <= DDS_DataIn;
                    DDS_PCLK    <= 1'b0;
                    DDS_CSn     <= 1'b1;
                    DDS_RWn     <= 1'b1;
                    DDS_ReadEn  <= 1'b0;
                    DDS_DataOut <= '0;
                    state       <= CS_HD;
                end else cnt <= cnt - 1'b1;
                CS_HD: if (!rw && io_up) begin
                    cnt      <= IW_LD;
                    DDS_IOup <= 1'b1;
                    state    <= IOUP;
                end
                IOUP: if (last) DDS_IOup <= 1'b0;
                      else cnt <= cnt - 1'b1;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (fin) begin
                state     <= DONE;
                req0_done <= !own;
                req1_done <= own;
                if (rw && !own) req0_rdata <= rbuf;
                if (rw && own) req1_rdata <= rbuf;
            end
        end
    end

endmodule

// File: tb/tb_dds_par_port_ctrl.sv
// tb_dds_par_port_ctrl: cycle-timetable model of the DDS port plus directed transactions
module tb_dds_par_port_ctrl;

    localparam int PH = 2;
    localparam int IW = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] v = '0, rw = '0, iou = '0;
    logic [7:0] addr [2];
    logic [7:0] wd [2];
    logic [7:0] din = 8'h11;
    logic       din_fix = 1'b0;
    logic [1:0] rdy, done;
    logic [7:0] rd0, rd1, dout;
    logic       busy, csn, rwn, pclk, ren, ioup;
    int         n_cmp = 0, n_bad = 0;
    int         lat, pk, re, io, cs, t, n;
    logic       order [4];

    always #5 clk = ~clk;

    dds_par_port_ctrl #(.PCLK_HALF(PH), .IOUP_W(IW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req0_valid  (v[0]),
        .req0_ready  (rdy[0]),
        .req0_rw     (rw[0]),
        .req0_addr   (addr[0]),
        .req0_wdata  (wd[0]),
        .req0_io_up  (iou[0]),
        .req0_done   (done[0]),
        .req0_rdata  (rd0),
        .req1_valid  (v[1]),
        .req1_ready  (rdy[1]),
        .req1_rw     (rw[1]),
        .req1_addr   (addr[1]),
        .req1_wdata  (wd[1]),
        .req1_io_up  (iou[1]),
        .req1_done   (done[1]),
        .req1_rdata  (rd1),
        .busy        (busy),
        .DDS_CSn     (csn),
        .DDS_RWn     (rwn),
        .DDS_PCLK    (pclk),
        .DDS_DataOut (dout),
        .DDS_ReadEn  (ren),
        .DDS_DataIn  (din),
        .DDS_IOup    (ioup)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // DataIn keeps changing every cycle so a mistimed sample gives a different byte
    initial forever begin
        @(posedge clk);
        #1;
        if (!din_fix) din = din + 8'h35;
    end

    // model: a transaction is a timetable of offsets from its ready cycle
    int         off = -1, own = 0, last_g = 1, done_off;
    logic       m_rw = 1'b0, m_iou = 1'b0, dph;
    logic [7:0] m_a = '0, m_w = '0, m_s = '0;
    logic [7:0] m_rd [2] = '{8'h00, 8'h00};

    always @(negedge clk) begin
        if (!rstn) begin
            off = -1;
            last_g = 1;
            m_rd[0] = 8'h00;
            m_rd[1] = 8'h00;
        end else if (off < 0 && v != 2'b00) begin
            own = (v == 2'b11) ? (last_g == 0 ? 1 : 0) : (v[1] ? 1 : 0);
            m_rw = rw[own];
            m_iou = iou[own];
            m_a = addr[own];
            m_w = wd[own];
            last_g = own;
            off = 0;
        end
        done_off = 3 + 4 * PH + ((!m_rw && m_iou) ? IW : 0);
        if (off == 1 + 4 * PH) m_s = din;
        if (off == done_off && m_rw) m_rd[own] = m_s;
        dph = off >= 2 + 2 * PH && off <= 1 + 4 * PH;
        chk("ready", rdy, off == 0 ? (own ? 2'b10 : 2'b01) : 2'b00);
        chk("busy", busy, off >= 1);
        chk("csn", csn, !(off >= 1 && off <= 1 + 4 * PH));
        chk("rwn", rwn, (off >= 1 && off <= 1 + 4 * PH) ? m_rw : 1'b1);
        chk("pclk", pclk, (off >= 2 + PH && off <= 1 + 2 * PH) || (off >= 2 + 3 * PH && off <= 1 + 4 * PH));
        chk("dout", dout, (off >= 1 && off <= 1 + 2 * PH) ? m_a : (dph && !m_rw) ? m_w : 8'h00);
        chk("readen", ren, dph && m_rw);
        chk("ioup", ioup, !m_rw && m_iou && off >= 3 + 4 * PH && off <= 2 + 4 * PH + IW);
        chk("done", done, off == done_off ? (own ? 2'b10 : 2'b01) : 2'b00);
        chk("rdata0", rd0, m_rd[0]);
        chk("rdata1", rd1, m_rd[1]);
        if (off >= 0) off = (off == done_off) ? -1 : off + 1;
    end

    task automatic do_txn(input int p, input logic r, input logic [7:0] a, input logic [7:0] d,
                          input logic iu, output int l, output int npk, output int nre,
                          output int nio, output int ncs);
        int w;
        @(posedge clk);
        #1;
        rw[p] = r;
        addr[p] = a;
        wd[p] = d;
        iou[p] = iu;
        v[p] = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rdy[p] && w < 100);
        chk("ready_seen", rdy[p], 1'b1);
        @(posedge clk);
        #1;
        v[p] = 1'b0;
        l = 0; npk = 0; nre = 0; nio = 0; ncs = 0;
        do begin
            @(negedge clk);
            l++;
            npk += int'(pclk);
            nre += int'(ren);
            nio += int'(ioup);
            ncs += int'(!csn);
        end while (!done[p] && l < 100);
        chk("done_seen", done[p], 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_csn", csn, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rwn", rwn, 1'b1);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        do_txn(0, 1'b0, 8'h04, 8'hA5, 1'b0, lat, pk, re, io, cs);
        chk("t1_latency", lat, 11);
        chk("t1_pclk_hi", pk, 4);
        chk("t1_csn_lo", cs, 9);
        chk("t1_readen", re, 0);

        din_fix = 1'b1;
        din = 8'h3C;
        do_txn(1, 1'b1, 8'h0B, 8'h77, 1'b0, lat, pk, re, io, cs);
        chk("t2_latency", lat, 11);
        chk("t2_readen", re, 4);
        chk("t2_rdata1", rd1, 8'h3C);
        chk("t2_rdata0", rd0, 8'h00);
        din_fix = 1'b0;

        do_txn(0, 1'b1, 8'h21, 8'h00, 1'b0, lat, pk, re, io, cs);
        chk("t2b_rdata1", rd1, 8'h3C);

        do_txn(0, 1'b0, 8'h0E, 8'h5A, 1'b1, lat, pk, re, io, cs);
        chk("t4_latency", lat, 15);
        chk("t4_ioup", io, 4);
        do_txn(1, 1'b1, 8'h0E, 8'h00, 1'b1, lat, pk, re, io, cs);
        chk("t4b_latency", lat, 11);
        chk("t4b_ioup", io, 0);

        @(posedge clk);
        #1;
        rw = 2'b10; iou = 2'b00;
        addr[0] = 8'h10; wd[0] = 8'h01; addr[1] = 8'h11; wd[1] = 8'h02;
        v = 2'b11;
        n = 0; t = 0;
        while (n < 4 && t < 400) begin
            @(negedge clk);
            t++;
            if (rdy != 2'b00) begin
                chk("t3_onehot", $countones(rdy), 1);
                order[n] = rdy[1];
                n++;
            end
        end
        @(posedge clk);
        #1 v = 2'b00;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 50);
        chk("t3_grants", n, 4);
        chk("t3_order0", order[0], 1'b0);
        chk("t3_order1", order[1], 1'b1);
        chk("t3_order2", order[2], 1'b0);
        chk("t3_order3", order[3], 1'b1);

        fork
            do_txn(1, 1'b0, 8'h30, 8'hC3, 1'b0, lat, pk, re, io, cs);
            begin
                repeat (4) @(posedge clk);
                #1;
                rw[0] = 1'b0; addr[0] = 8'h44; wd[0] = 8'h99; iou[0] = 1'b0;
                v[0] = 1'b1;
                @(posedge clk);
                #1 v[0] = 1'b0;
            end
        join
        chk("t6_latency", lat, 11);
        repeat (3) @(negedge clk);
        chk("t6_busy", busy, 1'b0);
        chk("t6_csn", csn, 1'b1);

        @(posedge clk);
        #1;
        rw[1] = 1'b1; addr[1] = 8'h0B; iou[1] = 1'b0;
        v[1] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rdy[1] && t < 50);
        chk("t5_ready", rdy[1], 1'b1);
        @(posedge clk);
        #1 v[1] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("t5_csn", csn, 1'b1);
        chk("t5_pclk", pclk, 1'b0);
        chk("t5_readen", ren, 1'b0);
        chk("t5_rdata1", rd1, 8'h00);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        do_txn(1, 1'b1, 8'h0B, 8'h00, 1'b0, lat, pk, re, io, cs);
        chk("t5_after_latency", lat, 11);
        do_txn(0, 1'b0, 8'h05, 8'h3E, 1'b0, lat, pk, re, io, cs);
        chk("t5_after_write", lat, 11);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
